// File: rtl/spi_master_sched_pkg.sv
// Shared definitions for the SPI master scheduler: FSM encoding, mode-0 bus levels
// and a width helper.
package spi_master_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic SCK_IDLE    = 1'b0;
    localparam logic SS_INACTIVE = 1'b1;

    // Width of an index into v items; never zero so single-entry configurations still elaborate.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/spi_master_sched_rr_arb.sv
// Round-robin arbiter: first set request at or after the pointer, wrapping.
// Purely combinational; the pointer register lives in the caller.
module rr_arb
    import spi_master_sched_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = clog2_min1(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        // NOTE: every output gets a default before the search loop so no latch is inferred.
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!o_valid && i_req[(int'(i_ptr) + i) % N]) begin
                o_valid                        = 1'b1;
                o_gnt[(int'(i_ptr) + i) % N]   = 1'b1;
                o_idx                          = PW'((int'(i_ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/spi_master_sched.sv
// SPI mode-0 master shared by NREQ requesters through round-robin arbitration;
// one frame per grant, framed by SETUP/HOLD/GAP half-periods of sck.
module spi_master_sched
    import spi_master_sched_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int NREQ        = 2,
    parameter int SCK_DIV     = 2
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*DATA_LENGTH-1:0] wdata,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             done,
    output logic [DATA_LENGTH-1:0]      rdata,
    output logic                        busy,
    output logic                        sck,
    output logic [NREQ-1:0]             ss,
    output logic                        mosi,
    input  logic                        miso
);

    localparam int DIV_W = clog2_min1(SCK_DIV);
    localparam int CNT_W = $clog2(DATA_LENGTH + 1);
    localparam int PTR_W = clog2_min1(NREQ);

    state_t                 r_state, w_next_state;
    logic [DIV_W-1:0]       r_div;
    logic [CNT_W-1:0]       r_bits;
    logic [PTR_W-1:0]       r_ptr, r_sel;
    logic [DATA_LENGTH-1:0] r_tx, r_rx;
    logic                   r_sck, r_mosi, r_busy;
    logic [NREQ-1:0]        r_gnt, r_done, r_ss;
    logic [DATA_LENGTH-1:0] r_rdata;

    logic [NREQ-1:0]        w_win;
    logic [PTR_W-1:0]       w_win_idx;
    logic                   w_valid;
    logic [DATA_LENGTH-1:0] w_word;
    logic                   w_tick, w_all_bits;
    logic                   w_start, w_rise, w_fall, w_last_fall, w_done_evt, w_gap_end;
    logic [NREQ-1:0]        w_done_vec;

    rr_arb #(.N(NREQ), .PW(PTR_W)) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_win),
        .o_idx   (w_win_idx),
        .o_valid (w_valid)
    );

    assign w_word     = wdata[int'(w_win_idx)*DATA_LENGTH +: DATA_LENGTH];
    assign w_tick     = (r_div == DIV_W'(SCK_DIV - 1));
    assign w_all_bits = (r_bits == CNT_W'(DATA_LENGTH));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_valid) w_next_state = ST_SETUP;
            ST_SETUP: if (w_tick) w_next_state = ST_XFER;
            // A trailing low half-period follows the last fall before HOLD begins.
            ST_XFER:  if (w_tick && !r_sck && w_all_bits) w_next_state = ST_HOLD;
            ST_HOLD:  if (w_tick) w_next_state = ST_GAP;
            ST_GAP:   if (w_tick) w_next_state = w_valid ? ST_SETUP : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_start     = w_valid && ((r_state == ST_IDLE) || (r_state == ST_GAP && w_tick));
        w_rise      = w_tick && ((r_state == ST_SETUP) ||
                                 (r_state == ST_XFER && !r_sck && !w_all_bits));
        w_fall      = w_tick && (r_state == ST_XFER) && r_sck;
        w_last_fall = w_fall && w_all_bits;
        w_done_evt  = w_tick && (r_state == ST_HOLD);
        w_gap_end   = w_tick && (r_state == ST_GAP);
        w_done_vec  = '0;
        for (int i = 0; i < NREQ; i++) w_done_vec[i] = (r_sel == PTR_W'(i));
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_div   <= '0;
            r_bits  <= '0;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sck   <= SCK_IDLE;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_ss    <= {NREQ{SS_INACTIVE}};
            r_rdata <= '0;
        end else begin
            r_div  <= (r_state == ST_IDLE || w_tick) ? '0 : r_div + 1'b1;
            r_gnt  <= w_start ? w_win : '0;
            r_done <= w_done_evt ? w_done_vec : '0;

            if (w_start) begin
                r_sel  <= w_win_idx;
                r_ptr  <= (w_win_idx == PTR_W'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
                r_ss   <= ~w_win;
                r_busy <= 1'b1;
                r_tx   <= w_word;
                r_mosi <= w_word[DATA_LENGTH-1];
                r_rx   <= '0;
                r_bits <= '0;
            end else if (w_gap_end) begin
                r_busy <= 1'b0;
            end

            if (w_rise) begin
                r_sck  <= 1'b1;
                r_rx   <= {r_rx[DATA_LENGTH-2:0], miso};
                r_bits <= r_bits + 1'b1;
            end

            if (w_fall) begin
                r_sck <= SCK_IDLE;
                if (!w_last_fall) begin
                    r_tx   <= r_tx << 1;
                    r_mosi <= r_tx[DATA_LENGTH-2];
                end
            end

            if (w_done_evt) begin
                r_ss    <= {NREQ{SS_INACTIVE}};
                r_mosi  <= 1'b0;
                r_rdata <= r_rx;
            end
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign busy  = r_busy;
    assign sck   = r_sck;
    assign ss    = r_ss;
    assign mosi  = r_mosi;

endmodule
